// File: rtl/mem_arb_types.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection: round-robin after rr_last, or lowest index first.
module mem_arb_picker
    import mem_arb_types::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_last,
    input  logic                 mode,
    output logic                 any_req,
    output logic [IDX_W-1:0]     winner
);

    // Scan the request vector in the order the selected policy dictates.
    always_comb begin
        int   idx;
        logic found;
        any_req = |req;
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        if (mode == PRIO_FIXED) begin
            // Walk downwards so the lowest requesting index is written last.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    winner = IDX_W'(i);
                end
            end
        end else begin
            // Start one past the previous winner and wrap around.
            for (int off = 1; off <= NUM_PORTS; off++) begin
                idx = int'(rr_last) + off;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!found && req[idx]) begin
                    winner = IDX_W'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter sharing one hold-until-resp memory bus; all outputs registered.
module mem_port_arbiter
    import mem_arb_types::*;
#(
    parameter  int NUM_PORTS     = 2,
    parameter  int ADDR_WIDTH    = 32,
    parameter  int DATA_WIDTH    = 32,
    parameter  int PRIORITY_MODE = 0,
    localparam int BE_WIDTH      = DATA_WIDTH / 8,
    localparam int IDX_W         = $clog2(NUM_PORTS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  req_read,
    input  logic [NUM_PORTS-1:0]                  req_write,
    input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]    req_byte_enable,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]                  req_resp,
    output logic [DATA_WIDTH-1:0]                 req_rdata,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [BE_WIDTH-1:0]                   mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    input  logic                                  mem_resp,
    output logic                                  grant_valid,
    output logic [IDX_W-1:0]                      grant_idx
);

    localparam logic MODE = (PRIORITY_MODE == 1) ? PRIO_FIXED : PRIO_RR;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       rr_last;
    logic                   any_req;
    logic [IDX_W-1:0]       winner;
    logic [NUM_PORTS-1:0]   req_any;

    // A port asserting both strobes is handled as a write.
    assign req_any = req_read | req_write;

    mem_arb_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req     (req_any),
        .rr_last (rr_last),
        .mode    (MODE),
        .any_req (any_req),
        .winner  (winner)
    );

    // State register; reset abandons any in-flight bus transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant on any request, complete on mem_resp, one RESP cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req)  state_d = BUSY;
            BUSY:    if (mem_resp) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the winner's request, forward it, return the completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last         <= IDX_W'(NUM_PORTS - 1);
            req_resp        <= '0;
            req_rdata       <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            grant_valid     <= 1'b0;
            grant_idx       <= '0;
        end else begin
            req_resp    <= '0;
            grant_valid <= (state_d != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        mem_write       <= req_write[winner];
                        mem_read        <= ~req_write[winner];
                        mem_byte_enable <= req_byte_enable[winner];
                        mem_address     <= req_address[winner];
                        mem_wdata       <= req_wdata[winner];
                        grant_idx       <= winner;
                        rr_last         <= winner;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        // mem_write still holds the op of the latched transaction.
                        if (!mem_write) begin
                            req_rdata <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        req_resp  <= NUM_PORTS'(1) << grant_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench driving three arbiter configurations against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int ND        = 3;
    localparam int NP [ND]   = '{2, 2, 3};
    localparam int MD [ND]   = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst;

    logic [2:0]       rd   [ND];
    logic [2:0]       wr   [ND];
    logic [2:0][3:0]  be   [ND];
    logic [2:0][31:0] addr [ND];
    logic [2:0][31:0] wd   [ND];
    logic [31:0]      mrd  [ND];
    logic             mrsp [ND];

    logic [2:0]  o_resp  [ND];
    logic [31:0] o_rdata [ND];
    logic        o_mrd   [ND];
    logic        o_mwr   [ND];
    logic [3:0]  o_be    [ND];
    logic [31:0] o_addr  [ND];
    logic [31:0] o_wd    [ND];
    logic        o_gv    [ND];
    logic [1:0]  o_gidx  [ND];

    logic [1:0] resp_a, resp_b;
    logic [2:0] resp_c;
    logic       gidx_a, gidx_b;
    logic [1:0] gidx_c;

    assign o_resp[0] = {1'b0, resp_a};
    assign o_resp[1] = {1'b0, resp_b};
    assign o_resp[2] = resp_c;
    assign o_gidx[0] = {1'b0, gidx_a};
    assign o_gidx[1] = {1'b0, gidx_b};
    assign o_gidx[2] = gidx_c;

    initial forever #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) u_a (
        .clk(clk), .rst(rst), .req_read(rd[0][1:0]), .req_write(wr[0][1:0]),
        .req_byte_enable(be[0][1:0]), .req_address(addr[0][1:0]), .req_wdata(wd[0][1:0]),
        .req_resp(resp_a), .req_rdata(o_rdata[0]), .mem_read(o_mrd[0]), .mem_write(o_mwr[0]),
        .mem_byte_enable(o_be[0]), .mem_address(o_addr[0]), .mem_wdata(o_wd[0]),
        .mem_rdata(mrd[0]), .mem_resp(mrsp[0]), .grant_valid(o_gv[0]), .grant_idx(gidx_a));

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1)) u_b (
        .clk(clk), .rst(rst), .req_read(rd[1][1:0]), .req_write(wr[1][1:0]),
        .req_byte_enable(be[1][1:0]), .req_address(addr[1][1:0]), .req_wdata(wd[1][1:0]),
        .req_resp(resp_b), .req_rdata(o_rdata[1]), .mem_read(o_mrd[1]), .mem_write(o_mwr[1]),
        .mem_byte_enable(o_be[1]), .mem_address(o_addr[1]), .mem_wdata(o_wd[1]),
        .mem_rdata(mrd[1]), .mem_resp(mrsp[1]), .grant_valid(o_gv[1]), .grant_idx(gidx_b));

    mem_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) u_c (
        .clk(clk), .rst(rst), .req_read(rd[2]), .req_write(wr[2]),
        .req_byte_enable(be[2]), .req_address(addr[2]), .req_wdata(wd[2]),
        .req_resp(resp_c), .req_rdata(o_rdata[2]), .mem_read(o_mrd[2]), .mem_write(o_mwr[2]),
        .mem_byte_enable(o_be[2]), .mem_address(o_addr[2]), .mem_wdata(o_wd[2]),
        .mem_rdata(mrd[2]), .mem_resp(mrsp[2]), .grant_valid(o_gv[2]), .grant_idx(gidx_c));

    // Model: one outstanding transaction per arbiter.
    // ph 0 = no transaction, 1 = on the bus, 2 = completion being reported.
    int          ph    [ND];
    int          mp    [ND];
    int          mg    [ND];
    int          ml    [ND];
    logic        mw    [ND];
    logic [31:0] ma    [ND];
    logic [31:0] mwd   [ND];
    logic [3:0]  mbe   [ND];
    logic [31:0] mrdat [ND];

    int   glog [ND][8];
    int   gn   [ND];
    int   rc   [ND];
    logic pstb [ND];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int pick(int d, logic [2:0] rq);
        if (MD[d] == 1) begin
            for (int i = 0; i < NP[d]; i++) if (rq[i]) return i;
        end else begin
            for (int off = 1; off <= NP[d]; off++) begin
                int j = (ml[d] + off) % NP[d];
                if (rq[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset_all();
        for (int d = 0; d < ND; d++) begin
            ph[d] = 0; mp[d] = 0; mg[d] = 0; ml[d] = NP[d] - 1; mw[d] = 1'b0;
            ma[d] = '0; mwd[d] = '0; mbe[d] = '0; mrdat[d] = '0;
        end
    endtask

    task automatic model_step_all();
        for (int d = 0; d < ND; d++) begin
            logic [2:0] rq;
            int w;
            rq = rd[d] | wr[d];
            if (rst) begin
                if (ph[d] == 0) begin
                    w = pick(d, rq);
                    if (w >= 0) begin
                        ph[d] = 1; mp[d] = w; mg[d] = w; ml[d] = w;
                        mw[d] = wr[d][w]; ma[d] = addr[d][w]; mbe[d] = be[d][w]; mwd[d] = wd[d][w];
                    end
                end else if (ph[d] == 1) begin
                    if (mrsp[d]) begin
                        if (!mw[d]) mrdat[d] = mrd[d];
                        ph[d] = 2;
                    end
                end else begin
                    ph[d] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < ND; d++) begin
            logic stb;
            chk($sformatf("d%0d mem_read", d),    32'(o_mrd[d]), 32'(ph[d] == 1 && !mw[d]));
            chk($sformatf("d%0d mem_write", d),   32'(o_mwr[d]), 32'(ph[d] == 1 && mw[d]));
            chk($sformatf("d%0d req_resp", d),    32'(o_resp[d]), (ph[d] == 2) ? (32'd1 << mp[d]) : 32'd0);
            chk($sformatf("d%0d grant_valid", d), 32'(o_gv[d]), 32'(ph[d] != 0));
            chk($sformatf("d%0d grant_idx", d),   32'(o_gidx[d]), 32'(mg[d]));
            chk($sformatf("d%0d req_rdata", d),   o_rdata[d], mrdat[d]);
            if (ph[d] == 1 || !rst) begin
                chk($sformatf("d%0d mem_address", d), o_addr[d], ma[d]);
                chk($sformatf("d%0d mem_be", d),      32'(o_be[d]), 32'(mbe[d]));
                chk($sformatf("d%0d mem_wdata", d),   o_wd[d], mwd[d]);
            end
            stb = o_mrd[d] | o_mwr[d];
            if (stb && !pstb[d] && gn[d] < 8) begin
                glog[d][gn[d]] = int'(o_gidx[d]);
                gn[d]++;
            end
            pstb[d] = stb;
            if (o_resp[d] != '0) rc[d]++;
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step_all();
        #2;
    endtask

    task automatic clear_log(int d);
        gn[d] = 0;
        rc[d] = 0;
    endtask

    task automatic check_log(int d, string nm, int n, int e0, int e1, int e2, int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        chk($sformatf("%s grant count", nm), 32'(gn[d]), 32'(n));
        for (int i = 0; i < n && i < gn[d]; i++)
            chk($sformatf("%s grant %0d", nm, i), 32'(glog[d][i]), 32'(e[i]));
    endtask

    // Wait for the bus strobe, then complete it after lat strobe cycles.
    task automatic respond(int d, int lat, logic [31:0] data);
        int n = 0;
        while (!(o_mrd[d] | o_mwr[d]) && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("d%0d strobe within bound", d), 32'(o_mrd[d] | o_mwr[d]), 32'd1);
        repeat (lat - 1) tick();
        mrsp[d] = 1'b1;
        mrd[d]  = data;
        tick();
        mrsp[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            rd[d] = '0; wr[d] = '0; be[d] = '0; addr[d] = '0; wd[d] = '0;
            mrd[d] = '0; mrsp[d] = 1'b0; pstb[d] = 1'b0; gn[d] = 0; rc[d] = 0;
        end
        model_reset_all();
        #1 rst = 1'b0;
        model_reset_all();
        repeat (3) tick();
        chk("reset grant_valid", 32'(o_gv[0]), 32'd0);
        chk("reset req_resp", 32'(o_resp[2]), 32'd0);
        rst = 1'b1;
        tick();

        // 1: reset while port 0 read is on the bus, then a stale mem_resp.
        rd[0] = 3'b001; addr[0][0] = 32'h0000_1000;
        tick();
        tick();
        rst = 1'b0;
        model_reset_all();
        #1;
        chk("mid-reset mem_read", 32'(o_mrd[0]), 32'd0);
        chk("mid-reset grant_valid", 32'(o_gv[0]), 32'd0);
        chk("mid-reset mem_address", o_addr[0], 32'd0);
        rd[0] = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        mrsp[0] = 1'b1; mrd[0] = 32'hBAD0_BAD0;
        tick();
        mrsp[0] = 1'b0;
        tick();
        chk("late mem_resp ignored", 32'(o_resp[0]), 32'd0);
        clear_log(0);
        rd[0] = 3'b011; addr[0][0] = 32'h0000_1000; addr[0][1] = 32'h0000_2000;
        respond(0, 1, 32'h1111_0000);
        chk("post-reset resp to port 0", 32'(o_resp[0]), 32'b001);
        rd[0] = '0;
        tick();
        check_log(0, "post-reset", 1, 0, 0, 0, 0);

        // 2: port 1 read held three cycles.
        rd[0] = 3'b010; addr[0][1] = 32'h0000_1000;
        tick();
        chk("t2 mem_read c1", 32'(o_mrd[0]), 32'd1);
        chk("t2 mem_address", o_addr[0], 32'h0000_1000);
        chk("t2 grant_idx", 32'(o_gidx[0]), 32'd1);
        tick();
        chk("t2 mem_read c2", 32'(o_mrd[0]), 32'd1);
        tick();
        chk("t2 mem_read c3", 32'(o_mrd[0]), 32'd1);
        mrsp[0] = 1'b1; mrd[0] = 32'hDEAD_BEEF;
        tick();
        mrsp[0] = 1'b0;
        chk("t2 mem_read dropped", 32'(o_mrd[0]), 32'd0);
        chk("t2 req_resp", 32'(o_resp[0]), 32'b010);
        chk("t2 req_rdata", o_rdata[0], 32'hDEAD_BEEF);
        rd[0] = '0;
        tick();
        chk("t2 resp one cycle", 32'(o_resp[0]), 32'd0);

        // 3: round-robin with ports 0 and 1 both reading continuously.
        clear_log(0);
        rd[0] = 3'b011; addr[0][0] = 32'h0000_0100; addr[0][1] = 32'h0000_0200;
        respond(0, 1, 32'hA5A5_0001);
        respond(0, 2, 32'hA5A5_0002);
        respond(0, 1, 32'hA5A5_0003);
        rd[0] = '0;
        tick();
        tick();
        check_log(0, "rr2", 3, 0, 1, 0, 0);
        chk("rr2 resp pulses", 32'(rc[0]), 32'd3);

        // 5: write with read also asserted; read data must survive.
        rd[0] = 3'b001; wr[0] = 3'b001; be[0][0] = 4'b0011;
        addr[0][0] = 32'h0000_0040; wd[0][0] = 32'h1234_5678;
        tick();
        chk("t5 mem_write", 32'(o_mwr[0]), 32'd1);
        chk("t5 mem_read", 32'(o_mrd[0]), 32'd0);
        chk("t5 mem_be", 32'(o_be[0]), 32'b0011);
        chk("t5 mem_wdata", o_wd[0], 32'h1234_5678);
        chk("t5 mem_address", o_addr[0], 32'h0000_0040);
        respond(0, 1, 32'hFFFF_FFFF);
        chk("t5 req_resp", 32'(o_resp[0]), 32'b001);
        chk("t5 req_rdata kept", o_rdata[0], 32'hA5A5_0003);
        rd[0] = '0; wr[0] = '0;
        tick();

        // 4: fixed priority, same stimulus; port 1 only after port 0 drops.
        clear_log(1);
        rd[1] = 3'b011; addr[1][0] = 32'h0000_0300; addr[1][1] = 32'h0000_0400;
        respond(1, 1, 32'hC0DE_0001);
        respond(1, 1, 32'hC0DE_0002);
        respond(1, 1, 32'hC0DE_0003);
        rd[1] = 3'b010;
        respond(1, 1, 32'hC0DE_0004);
        rd[1] = '0;
        tick();
        tick();
        check_log(1, "fixed", 4, 0, 0, 0, 1);
        chk("fixed last rdata", o_rdata[1], 32'hC0DE_0004);

        // 6: three ports, spurious mem_resp in IDLE, then ports 0 and 2 contend.
        mrsp[2] = 1'b1; mrd[2] = 32'h5555_5555;
        tick();
        mrsp[2] = 1'b0;
        tick();
        chk("spurious resp", 32'(o_resp[2]), 32'd0);
        chk("spurious grant_valid", 32'(o_gv[2]), 32'd0);
        chk("spurious rdata", o_rdata[2], 32'd0);
        clear_log(2);
        rd[2] = 3'b101; addr[2][0] = 32'h0000_0500; addr[2][2] = 32'h0000_0700;
        respond(2, 1, 32'hBEEF_0001);
        respond(2, 3, 32'hBEEF_0002);
        respond(2, 1, 32'hBEEF_0003);
        rd[2] = '0;
        tick();
        tick();
        check_log(2, "rr3", 3, 0, 2, 0, 0);
        chk("rr3 resp pulses", 32'(rc[2]), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
